// File: rtl/painterengine_gpu_writer_arbiter.sv
// Round-robin arbiter granting one of four requesters exclusive use of a single DMA writer.
// Each job sequences router select, a rearm hold in reset, run with timeout, then a one-cycle ack/err.
module painterengine_gpu_writer_arbiter #(
  parameter int PARAM_REARM_CYCLES   = 4,
  parameter int PARAM_TIMEOUT_CYCLES = 65535
) (
  input  logic       i_wire_clock,
  input  logic       i_wire_resetn,
  input  logic [3:0] i_wire_req,
  output logic [3:0] o_wire_ack,
  output logic [3:0] o_wire_err,
  output logic [2:0] o_wire_err_type,
  output logic [3:0] o_wire_writer_router,
  output logic       o_wire_writer_resetn,
  input  logic       i_wire_writer_done,
  input  logic       i_wire_writer_error,
  input  logic [2:0] i_wire_writer_error_type,
  output logic       o_wire_busy,
  output logic [1:0] o_wire_grant_index
);

  localparam logic [7:0]  REARM_LAST   = 8'(PARAM_REARM_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(PARAM_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN, ST_COMPLETE} state_t;

  state_t      state;
  logic [1:0]  last_grant;
  logic [7:0]  rearm_cnt;
  logic [15:0] timeout_cnt;

  logic        pick_vld;
  logic [1:0]  pick;
  logic [1:0]  idx;

  // Search starts just past the last winner, so the previous winner is checked last.
  always_comb begin
    pick_vld = 1'b0;
    pick     = last_grant;
    idx      = last_grant;
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant + i[1:0];
      if (!pick_vld && i_wire_req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  assign o_wire_busy = (state != ST_IDLE);

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state                <= ST_IDLE;
      last_grant           <= 2'd3;
      o_wire_grant_index   <= 2'd0;
      o_wire_ack           <= 4'h0;
      o_wire_err           <= 4'h0;
      o_wire_err_type      <= 3'h0;
      o_wire_writer_router <= 4'h0;
      o_wire_writer_resetn <= 1'b0;
      rearm_cnt            <= 8'd0;
      timeout_cnt          <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_wire_writer_resetn <= 1'b0;
          o_wire_writer_router <= 4'h0;
          if (pick_vld) begin
            o_wire_grant_index   <= pick;
            last_grant           <= pick;
            o_wire_writer_router <= 4'(1 << pick);
            rearm_cnt            <= 8'd0;
            state                <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (rearm_cnt == REARM_LAST) begin
            o_wire_writer_resetn <= 1'b1;
            timeout_cnt          <= 16'd0;
            state                <= ST_RUN;
          end else begin
            rearm_cnt <= rearm_cnt + 8'd1;
          end
        end
        ST_RUN: begin
          timeout_cnt <= timeout_cnt + 16'd1;
          // Error outranks done, done outranks timeout; any exit releases the writer.
          if (i_wire_writer_error) begin
            o_wire_err      <= o_wire_writer_router;
            o_wire_err_type <= i_wire_writer_error_type;
          end else if (i_wire_writer_done) begin
            o_wire_ack <= o_wire_writer_router;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            o_wire_err      <= o_wire_writer_router;
            o_wire_err_type <= 3'h7;
          end
          if (i_wire_writer_error || i_wire_writer_done || timeout_cnt == TIMEOUT_LAST) begin
            o_wire_writer_resetn <= 1'b0;
            o_wire_writer_router <= 4'h0;
            state                <= ST_COMPLETE;
          end
        end
        ST_COMPLETE: begin
          o_wire_ack <= 4'h0;
          o_wire_err <= 4'h0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_writer_arbiter.sv
// Randomized bench: a job-level reference model predicts winner, timing and outcome of each job.
module tb_painterengine_gpu_writer_arbiter;

  localparam int REARM = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] ack, err, router;
  logic [2:0] err_type, wr_etype;
  logic       wr_rstn, wr_done, wr_error, busy;
  logic [1:0] gidx;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int         last;
  logic [2:0] last_type;

  painterengine_gpu_writer_arbiter #(
    .PARAM_REARM_CYCLES(REARM),
    .PARAM_TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_wire_clock(clk),
    .i_wire_resetn(rst_n),
    .i_wire_req(req),
    .o_wire_ack(ack),
    .o_wire_err(err),
    .o_wire_err_type(err_type),
    .o_wire_writer_router(router),
    .o_wire_writer_resetn(wr_rstn),
    .i_wire_writer_done(wr_done),
    .i_wire_writer_error(wr_error),
    .i_wire_writer_error_type(wr_etype),
    .o_wire_busy(busy),
    .o_wire_grant_index(gidx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One job: request r; writer raises its outcome on RUN cycle d (kind 0 done, 1 error, 2 both).
  task automatic run_job(input logic [3:0] r, input int d, input int kind, input logic [2:0] et);
    int w, arm, k, e;
    logic [3:0] oh;
    bit fail;
    @(negedge clk);
    req = r;
    w = -1;
    for (int i = 1; i <= 4; i++) begin
      if (w < 0 && r[(last + i) % 4]) w = (last + i) % 4;
    end
    last = w;
    oh   = 4'(1 << w);
    e    = (d < TMO) ? d : TMO - 1;
    fail = (d >= TMO) || (kind != 0);
    if (fail) last_type = (d < TMO) ? et : 3'h7;

    @(posedge clk); #1;
    chk("grant_router", router, oh);
    chk("grant_idx", gidx, w);
    chk("grant_busy", busy, 1);
    chk("grant_rstn", wr_rstn, 0);
    arm = 1;
    while (wr_rstn == 1'b0 && arm <= 300) begin
      @(negedge clk);
      req = 4'($urandom);
      @(posedge clk); #1;
      if (!wr_rstn) begin
        if (router !== oh) chk("arm_router", router, oh);
        arm++;
      end
    end
    chk("arm_len", arm, REARM);
    if (arm > 300) return;

    k = 0;
    while (k < 100) begin
      @(negedge clk);
      req = 4'($urandom);
      if (k >= d) begin
        wr_done  = (kind != 1);
        wr_error = (kind != 0);
        wr_etype = et;
      end
      @(posedge clk); #1;
      if ((ack | err) != 4'h0) break;
      if (wr_rstn !== 1'b1 || router !== oh) begin
        chk("run_rstn", wr_rstn, 1);
        chk("run_router", router, oh);
      end
      k++;
    end
    chk("run_len", k, e);
    chk("cpl_ack", ack, fail ? 4'h0 : oh);
    chk("cpl_err", err, fail ? oh : 4'h0);
    chk("cpl_err_type", err_type, last_type);
    chk("cpl_rstn", wr_rstn, 0);
    chk("cpl_router", router, 0);

    @(negedge clk);
    wr_done = 0; wr_error = 0; req = 4'h0;
    @(posedge clk); #1;
    chk("idle_pulse", {ack, err}, 8'h00);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    req = 0; wr_done = 0; wr_error = 0; wr_etype = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_err_type", err_type, 0);
    chk("rst_router", router, 0);
    chk("rst_wr_rstn", wr_rstn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gidx", gidx, 0);
    last = 3; last_type = 3'h0;
    @(negedge clk) rst_n = 1'b1;

    // fairness with all requesters pending: 0,1,2,3,0
    repeat (5) run_job(4'b1111, 3, 0, 3'h0);
    run_job(4'b0100, 10, 0, 3'h0);
    run_job(4'b0011, 5, 1, 3'h2);
    run_job(4'b1001, 3, 2, 3'h5);
    run_job(4'b0110, 40, 0, 3'h1);
    run_job(4'b1000, 0, 0, 3'h0);
    run_job(4'b0001, 0, 1, 3'h4);

    for (int n = 0; n < 40; n++)
      run_job(4'($urandom_range(1, 15)), $urandom_range(0, 20), $urandom_range(0, 2),
              3'($urandom_range(0, 7)));

    // asynchronous reset in the middle of RUN
    @(negedge clk) req = 4'b0100;
    for (int c = 0; c < 20 && !wr_rstn; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_rstn", wr_rstn, 0);
    chk("mid_rst_router", router, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err_type", err_type, 0);
    req = 4'h0;
    @(negedge clk) rst_n = 1'b1;
    last = 3; last_type = 3'h0;
    run_job(4'b1000, 5, 0, 3'h0);
    run_job(4'b1111, 2, 0, 3'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
